knns_run_ctrl: RTL

Run sequencer for the sequential k-nearest-neighbour search datapath (`k_nns_seq_td`). It accepts a query point and a point count, clears the datapath, and streams candidate points into it over a valid/ready interface. It then waits out the datapath latency and latches the K-entry minimum-distance vector as the run result. It sits between the point source (memory reader or garbled-input feeder) and the datapath, and is the only agent that drives the datapath reset and inputs.

---
 rtl/knns_run_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/knns_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : knns_run_ctrl
// Description : Run sequencer for the sequential k-nearest-neighbour search
//               datapath. It latches a query point and a point count, holds
//               the datapath in reset for CLR_CYCLES cycles, and streams
//               candidate points in over a valid/ready handshake. It then
//               waits DP_LAT cycles for the datapath pipeline and latches the
//               K-entry minimum-distance vector as the run result.
// Ports       : clk, rst (sync, active-low)
//               start, query_x/query_y, num_pts -> run request (IDLE only)
//               busy                            -> run in progress
//               pt_valid/pt_ready, pt_x/pt_y    -> candidate point stream
//               dp_rst, dp_en, dp_x1/dp_y1,
//               dp_x2/dp_y2, dp_min_val         -> datapath control/data
//               result, done                    -> run result and pulse
// Revision    : 1.0 - initial release
// ============================================================================
module knns_run_ctrl #(
  parameter int W          = 32,
  parameter int K          = 20,
  parameter int CNT_W      = 16,
  parameter int CLR_CYCLES = 2,   // must be >= 1
  parameter int DP_LAT     = 1    // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     query_x,
  input  logic [W-1:0]     query_y,
  input  logic [CNT_W-1:0] num_pts,
  output logic             busy,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [W-1:0]     pt_x,
  input  logic [W-1:0]     pt_y,
  output logic             dp_rst,
  output logic             dp_en,
  output logic [W-1:0]     dp_x1,
  output logic [W-1:0]     dp_y1,
  output logic [W-1:0]     dp_x2,
  output logic [W-1:0]     dp_y2,
  input  logic [K*W-1:0]   dp_min_val,
  output logic [K*W-1:0]   result,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  // Counters only need to reach CLR_CYCLES-1 / DP_LAT-1.
  localparam int c_CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int c_LAT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  localparam logic [c_CLR_W-1:0] c_CLR_LAST = c_CLR_W'(CLR_CYCLES - 1);
  localparam logic [c_CLR_W-1:0] c_CLR_ONE  = c_CLR_W'(1);
  localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(DP_LAT - 1);
  localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_pt_ready;
  logic                 r_dp_rst;
  logic                 r_done;
  logic [W-1:0]         r_qx;
  logic [W-1:0]         r_qy;
  logic [K*W-1:0]       r_result;
  logic [CNT_W-1:0]     r_remaining;
  logic [c_CLR_W-1:0]   r_clr_cnt;
  logic [c_LAT_W-1:0]   r_lat_cnt;

  logic                 w_stream;
  logic                 w_hs;

  assign w_stream = (r_state == S_STREAM);
  // r_pt_ready is high exactly while in STREAM.
  assign w_hs     = pt_valid & r_pt_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_pt_ready  <= 1'b0;
      r_dp_rst    <= 1'b0;
      r_done      <= 1'b0;
      r_qx        <= '0;
      r_qy        <= '0;
      r_result    <= '0;
      r_remaining <= '0;
      r_clr_cnt   <= '0;
      r_lat_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A zero-length run is ignored outright.
          if (start && (num_pts != '0)) begin
            r_qx        <= query_x;
            r_qy        <= query_y;
            r_remaining <= num_pts;
            r_clr_cnt   <= '0;
            r_busy      <= 1'b1;
            r_dp_rst    <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == c_CLR_LAST) begin
            r_dp_rst   <= 1'b0;
            r_pt_ready <= 1'b1;
            r_state    <= S_STREAM;
          end else begin
            r_clr_cnt <= r_clr_cnt + c_CLR_ONE;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            r_remaining <= r_remaining - c_CNT_ONE;
            if (r_remaining == c_CNT_ONE) begin
              r_pt_ready <= 1'b0;
              r_lat_cnt  <= '0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Final point has propagated through the datapath on the last edge.
          if (r_lat_cnt == c_LAT_LAST) begin
            r_result <= dp_min_val;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt + c_LAT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign pt_ready = r_pt_ready;
  assign dp_rst   = r_dp_rst;
  assign done     = r_done;
  assign result   = r_result;
  assign dp_x1    = r_qx;
  assign dp_y1    = r_qy;

  // Candidate point passes straight through while streaming; zero otherwise.
  assign dp_en = w_stream & pt_valid;
  assign dp_x2 = w_stream ? pt_x : '0;
  assign dp_y2 = w_stream ? pt_y : '0;

endmodule
`default_nettype wire
